// File: rtl/dm_cache_hierarchy.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_hierarchy (with package cache_definition)
//  Description : Direct-mapped, write-back, write-allocate cache between a
//                16-bit word-addressed CPU port and an external async SRAM
//                bank of four parallel 16-bit chips (one 64-bit line per
//                SRAM address).
//  Ports       : clk, rst (async, active-high)
//                cpu_to_cache  - {addr[19:0], data[15:0], rw, valid}
//                cache_to_cpu  - {data[15:0], ready}
//                CE_N/OE_N/WE_N/LB_N/UB_N - SRAM strobes, active-low
//                mem_addr[19:0] - SRAM line address {2'b00, tag, index}
//                mem_data[63:0] - SRAM data bus, driven only in write-back
//                hit_count/miss_count [15:0] - only with CACHE_STATS_EN
//  Options     : `define CACHE_STATS_EN adds saturating hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================

package cache_definition;
    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
        logic        rw;
        logic        valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [15:0] data;
        logic        ready;
    } cache_to_cpu_type;
endpackage

module dm_cache_hierarchy
    import cache_definition::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int MEM_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  cpu_to_cache_type cpu_to_cache,
    output cache_to_cpu_type cache_to_cpu,
    output logic             CE_N,
    output logic             OE_N,
    output logic             WE_N,
    output logic             LB_N,
    output logic             UB_N,
    output logic [19:0]      mem_addr,
    inout  wire  [63:0]      mem_data
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);

    localparam int TAG_BITS = 18 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int CNT_W    = $clog2(MEM_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Registered request
    logic [19:0]           addr_q;
    logic [15:0]           wdata_q;
    logic                  rw_q;

    // Line storage
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [63:0]           line_q [LINES];

    logic [15:0]           rdata_q;
    logic                  ready_q;
    logic [19:0]           mem_addr_q;

    logic [INDEX_BITS-1:0] w_index;
    logic [1:0]            w_offset;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic [63:0]           w_line;

    logic                  w_accept;
    logic                  w_hit_done;
    logic                  w_alloc_done;
    logic                  w_wb_done;

    assign w_offset = addr_q[1:0];
    assign w_index  = addr_q[INDEX_BITS+1:2];
    assign w_tag    = addr_q[19:INDEX_BITS+2];
    assign w_line   = line_q[w_index];
    assign w_hit    = valid_q[w_index] && (tag_q[w_index] == w_tag);

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_accept     = 1'b0;
        w_hit_done   = 1'b0;
        w_alloc_done = 1'b0;
        w_wb_done    = 1'b0;
        CE_N         = 1'b1;
        OE_N         = 1'b1;
        WE_N         = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cpu_to_cache.valid) begin
                    w_accept = 1'b1;
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                cnt_d = '0;
                if (w_hit) begin
                    w_hit_done = 1'b1;
                    state_d    = S_IDLE;
                end else if (dirty_q[w_index]) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                // MEM_CYCLES clocks of write strobe, then one hold clock
                // with WE_N released while address and data stay put.
                CE_N = 1'b0;
                if (cnt_q == CNT_W'(MEM_CYCLES)) begin
                    w_wb_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_ALLOCATE;
                end else begin
                    WE_N  = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ALLOCATE: begin
                CE_N = 1'b0;
                OE_N = 1'b0;
                if (cnt_q == CNT_W'(MEM_CYCLES - 1)) begin
                    w_alloc_done = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign LB_N         = CE_N;
    assign UB_N         = CE_N;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = (state_q == S_WRITE_BACK) ? w_line : 64'hz;
    assign cache_to_cpu = {rdata_q, ready_q};

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= w_hit_done;

            if (w_accept) begin
                addr_q  <= cpu_to_cache.addr;
                wdata_q <= cpu_to_cache.data;
                rw_q    <= cpu_to_cache.rw;
            end

            if (w_hit_done) begin
                if (rw_q) begin
                    dirty_q[w_index] <= 1'b1;
                end else begin
                    rdata_q <= w_line[{w_offset, 4'b0000} +: 16];
                end
            end

            // A miss points the SRAM at the victim line when it must be
            // written back, otherwise straight at the line to fetch.
            if (state_q == S_COMPARE && !w_hit) begin
                if (dirty_q[w_index]) begin
                    mem_addr_q <= {2'b00, tag_q[w_index], w_index};
                end else begin
                    mem_addr_q <= {2'b00, w_tag, w_index};
                end
            end
            if (w_wb_done) begin
                mem_addr_q <= {2'b00, w_tag, w_index};
            end

            if (w_alloc_done) begin
                valid_q[w_index] <= 1'b1;
                dirty_q[w_index] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (no reset: guarded by valid_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_hit_done && rw_q) begin
            line_q[w_index][{w_offset, 4'b0000} +: 16] <= wdata_q;
        end
        if (w_alloc_done) begin
            line_q[w_index] <= mem_data;
            tag_q[w_index]  <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    // Set when COMPARE is re-entered after a fill so the second pass of
    // the same request is not counted again.
    logic recompare_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count   <= '0;
            miss_count  <= '0;
            recompare_q <= 1'b0;
        end else begin
            if (w_alloc_done) begin
                recompare_q <= 1'b1;
            end else if (w_accept) begin
                recompare_q <= 1'b0;
            end
            if (state_q == S_COMPARE && !recompare_q) begin
                if (w_hit) begin
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                end else begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_cache_hierarchy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_cache_hierarchy
//  Description : Scoreboard bench for dm_cache_hierarchy with four
//                behavioural async SRAM chips on the mem_data slices and a
//                flat-memory / tag-table reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_hierarchy;
    import cache_definition::*;

    localparam int MC = 2;
    localparam int IB = 8;

    logic             clk;
    logic             rst;
    cpu_to_cache_type req;
    cache_to_cpu_type rsp;
    logic             CE_N, OE_N, WE_N, LB_N, UB_N;
    logic [19:0]      mem_addr;
    wire  [63:0]      mem_data;
`ifdef CACHE_STATS_EN
    logic [15:0]      hit_count, miss_count;
`endif

    dm_cache_hierarchy #(.INDEX_BITS(IB), .MEM_CYCLES(MC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_to_cache (req),
        .cache_to_cpu (rsp),
        .CE_N         (CE_N),
        .OE_N         (OE_N),
        .WE_N         (WE_N),
        .LB_N         (LB_N),
        .UB_N         (UB_N),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ------------------------------------------------------------------
    // Four async SRAM chips, one per 16-bit lane
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_sram
        logic [15:0] mem [0:(1<<20)-1];
        initial for (int a = 0; a < (1 << 20); a++) mem[a] = 16'h0;
        always @(negedge clk)
            if (!CE_N && !WE_N) mem[mem_addr] <= mem_data[16*k +: 16];
        assign mem_data[16*k +: 16] = (!CE_N && !OE_N && WE_N) ? mem[mem_addr] : 16'hz;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // SRAM bus observer and strobe invariants
    // ------------------------------------------------------------------
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    logic [19:0] last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;
    logic [19:0] last_rd_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("we_oe_exclusive", {62'b0, WE_N, OE_N} == 64'b0 ? 64'b1 : 64'b0, 64'b0);
            chk("byte_lanes", {62'b0, LB_N, UB_N}, {62'b0, CE_N, CE_N});
            if (!CE_N && !WE_N) begin
                wr_cycles++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_data;
            end
            if (!CE_N && !OE_N) begin
                rd_cycles++;
                last_rd_addr = mem_addr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: flat word memory plus per-index tag table
    // ------------------------------------------------------------------
    typedef struct {
        logic        is_read;
        logic [15:0] data;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sbq [$];
    logic [15:0] ref_mem [int];
    bit          m_valid [int];
    bit          m_dirty [int];
    int          m_tag   [int];

    function automatic logic [15:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every ready pulse against the scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst && rsp.ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("latency", 64'(cycle - e.t0), 64'(e.lat));
                    if (e.is_read) chk("read_data", 64'(rsp.data), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request (called just after a rising edge) and wait for ready.
    task automatic do_req(input logic [19:0] a, input logic rw, input logic [15:0] d);
        exp_t e;
        int   idx, tg;
        bit   hit;
        bit   seen;
        idx = int'(a[IB+1:2]);
        tg  = int'(a[19:IB+2]);
        hit = m_valid.exists(idx) && m_valid[idx] && (m_tag[idx] == tg);
        if (hit)                                      e.lat = 2;
        else if (m_dirty.exists(idx) && m_dirty[idx]) e.lat = 4 + 2*MC;
        else                                          e.lat = 3 + MC;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (rw) begin
            m_dirty[idx]    = 1'b1;
            ref_mem[int'(a)] = d;
        end else if (!hit) begin
            m_dirty[idx] = 1'b0;
        end
        e.is_read = !rw;
        e.data    = ref_read(int'(a));
        e.t0      = cycle;
        sbq.push_back(e);

        req = '{addr: a, data: d, rw: rw, valid: 1'b1};
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp.ready) begin
                seen = 1'b1;
                break;
            end
        end
        req.valid = 1'b0;
        req.rw    = $urandom_range(0, 1);
        req.data  = 16'($urandom);
        if (!seen) begin
            chk("ready_timeout", 64'd0, 64'd1);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int w0, r0;
        bit seen;
        req = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rsp.ready), 64'd0);
        chk("rst_data", 64'(rsp.data), 64'd0);
        chk("rst_strobes", {59'b0, CE_N, OE_N, WE_N, LB_N, UB_N}, 64'h1F);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
`ifdef CACHE_STATS_EN
        chk("rst_stats", {32'b0, hit_count, miss_count}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Cold write: clean miss, fill from line 0, no write-back
        w0 = wr_cycles; r0 = rd_cycles;
        do_req(20'h00000, 1'b1, 16'h0001);
        chk("cold_no_wb", 64'(wr_cycles - w0), 64'd0);
        chk("cold_fill_cycles", 64'(rd_cycles - r0), 64'(MC));
        chk("cold_fill_addr", 64'(last_rd_addr), 64'h00000);

        // Write hit: no SRAM activity
        w0 = wr_cycles; r0 = rd_cycles;
        do_req(20'h00001, 1'b1, 16'h0002);
        chk("hit_no_sram", 64'((wr_cycles - w0) + (rd_cycles - r0)), 64'd0);

        // Conflict read: dirty victim written back, then new line filled
        w0 = wr_cycles;
        do_req(20'h80000, 1'b0, 16'h0000);
        chk("wb_cycles", 64'(wr_cycles - w0), 64'(MC));
        chk("wb_addr", 64'(last_wr_addr), 64'h00000);
        chk("wb_data", last_wr_data, 64'h0000_0000_0002_0001);
        chk("wb_fill_addr", 64'(last_rd_addr), 64'h20000);

        // Clean miss back to line 0
        w0 = wr_cycles;
        do_req(20'h00001, 1'b0, 16'h0000);
        chk("clean_no_wb", 64'(wr_cycles - w0), 64'd0);
        chk("clean_fill_addr", 64'(last_rd_addr), 64'h00000);
`ifdef CACHE_STATS_EN
        chk("hit_count", 64'(hit_count), 64'd1);
        chk("miss_count", 64'(miss_count), 64'd3);
`endif

        // Reset in the middle of a fill
        req = '{addr: 20'h00104, data: 16'h0, rw: 1'b0, valid: 1'b1};
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!OE_N) begin
                seen = 1'b1;
                break;
            end
        end
        chk("alloc_seen", 64'(seen), 64'd1);
        #2;
        rst = 1'b1;
        req.valid = 1'b0;
        #1;
        chk("abort_strobes", {61'b0, CE_N, OE_N, WE_N}, 64'h7);
        chk("abort_ready", 64'(rsp.ready), 64'd0);
        chk("abort_data", 64'(rsp.data), 64'd0);
        m_valid.delete();
        m_dirty.delete();
        m_tag.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        r0 = rd_cycles;
        do_req(20'h00104, 1'b0, 16'h0000);
        chk("after_rst_miss", 64'(rd_cycles - r0), 64'(MC));

        // Randomized traffic over a few indices and tags to force conflicts
        for (int n = 0; n < 200; n++) begin
            logic [19:0] a;
            a = 20'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            do_req(a, 1'($urandom_range(0, 1)), 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
